// File: rtl/amstrad_scandoubler.sv
// -----------------------------------------------------------------------------
// amstrad_scandoubler
//
// Line-doubling video stage for the motherboard video outputs. Each 15 kHz
// input line is captured into one half of a ping-pong line buffer while the
// other half (the previous line) is played back twice at the full clk rate,
// giving a 31 kHz stream. Output therefore lags input by one input line.
// In bypass mode the native stream is passed through, registered on ce_in.
//
// Ports:
//   clk                        system clock, exactly 2x the input pixel rate
//   reset_n                    asynchronous active-low reset
//   sd_en                      1 = scandouble, 0 = bypass (taken at line start)
//   ce_in                      input pixel enable, every other clk
//   red_in/green_in/blue_in    2-bit input colour
//   hblank_in/vblank_in        input blanking
//   hsync_in/vsync_in          input syncs, active high
//   red_out/green_out/blue_out 2-bit output colour
//   hblank_out/vblank_out      output blanking
//   hsync_out/vsync_out        output syncs
//   line_len                   last accepted input line length in ce_in ticks
// -----------------------------------------------------------------------------
module amstrad_scandoubler #(
    parameter int ADDR_W   = 10,
    parameter int MIN_LINE = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sd_en,
    input  logic              ce_in,
    input  logic [1:0]        red_in,
    input  logic [1:0]        green_in,
    input  logic [1:0]        blue_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    output logic [1:0]        red_out,
    output logic [1:0]        green_out,
    output logic [1:0]        blue_out,
    output logic              hblank_out,
    output logic              vblank_out,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic [ADDR_W:0]   line_len
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LINE_MAX = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   MIN_LEN  = (ADDR_W+1)'(MIN_LINE);
    localparam logic [ADDR_W:0]   LEN_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LEN_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W-1:0] POS_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] POS_ZERO = ADDR_W'(0);

    // Two line halves selected by the top address bit: {buf_sel, pos}.
    logic [6:0]        r_mem [0:2*DEPTH-1];

    logic [ADDR_W:0]   r_wpos;
    logic [ADDR_W:0]   r_line_len;
    logic [ADDR_W:0]   r_hs_cnt;
    logic [ADDR_W:0]   r_hs_w;
    logic [ADDR_W-1:0] r_rpos;
    logic              r_buf_sel;
    logic              r_hs_prev;
    logic              r_hs_valid;
    logic              r_sd_mode;

    logic [1:0]        r_red_out;
    logic [1:0]        r_green_out;
    logic [1:0]        r_blue_out;
    logic              r_hblank_out;
    logic              r_vblank_out;
    logic              r_hsync_out;
    logic              r_vsync_out;

    logic              w_hs_rise;
    logic              w_hs_fall;
    logic              w_line_start;
    logic              w_rpos_wrap;
    logic              w_mode_sd;
    logic              w_wr_en;
    logic [ADDR_W:0]   w_wr_addr;
    logic [6:0]        w_wr_data;
    logic [ADDR_W:0]   w_rd_addr;

    assign w_hs_rise    = ce_in & hsync_in & ~r_hs_prev;
    assign w_hs_fall    = ce_in & ~hsync_in & r_hs_prev;
    // Short lines are hsync glitches and never start a new line.
    assign w_line_start = w_hs_rise & (r_wpos >= MIN_LEN);
    assign w_rpos_wrap  = (r_line_len != LEN_ZERO) &&
                          ({1'b0, r_rpos} == (r_line_len - LEN_ONE));
    // Until a line has been accepted there is nothing to tear, so sd_en acts
    // directly; afterwards the mode latched at the last line start is used.
    assign w_mode_sd    = (r_line_len == LEN_ZERO) ? sd_en : r_sd_mode;
    assign w_rd_addr    = {~r_buf_sel, r_rpos};

    // Line-buffer write port: line start writes address 0 of the new half.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = {r_buf_sel, r_wpos[ADDR_W-1:0]};
        w_wr_data = {hblank_in, red_in, green_in, blue_in};
        if (w_line_start) begin
            w_wr_en   = 1'b1;
            w_wr_addr = {~r_buf_sel, POS_ZERO};
        end else if (ce_in && (r_wpos < LINE_MAX)) begin
            w_wr_en   = 1'b1;
        end else begin
            w_wr_en   = 1'b0;
        end
    end

    // Line-buffer storage; contents are not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Input side: write position, line length, buffer swap, hsync width.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wpos     <= LEN_ZERO;
            r_line_len <= LEN_ZERO;
            r_hs_cnt   <= LEN_ZERO;
            r_hs_w     <= LEN_ZERO;
            r_buf_sel  <= 1'b0;
            r_hs_prev  <= 1'b0;
            r_hs_valid <= 1'b0;
            r_sd_mode  <= 1'b0;
        end else if (ce_in) begin
            r_hs_prev <= hsync_in;
            if (w_line_start) begin
                r_line_len <= r_wpos;
                r_buf_sel  <= ~r_buf_sel;
                r_wpos     <= LEN_ONE;
                r_hs_cnt   <= LEN_ONE;
                r_hs_valid <= 1'b1;
                r_sd_mode  <= sd_en;
            end else begin
                if (r_wpos < LINE_MAX) begin
                    r_wpos <= r_wpos + LEN_ONE;
                end
                if (hsync_in && (r_hs_cnt < LINE_MAX)) begin
                    r_hs_cnt <= r_hs_cnt + LEN_ONE;
                end
            end
            // Only the pulse that opened an accepted line defines the width,
            // so a glitch pulse cannot disturb the output sync.
            if (w_hs_fall) begin
                if (r_hs_valid) begin
                    r_hs_w <= r_hs_cnt;
                end
                r_hs_valid <= 1'b0;
            end
        end
    end

    // Output read position: restarts on line start, otherwise wraps at line_len.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rpos <= POS_ZERO;
        end else if (w_line_start) begin
            r_rpos <= POS_ZERO;
        end else if (w_rpos_wrap) begin
            r_rpos <= POS_ZERO;
        end else begin
            r_rpos <= r_rpos + POS_ONE;
        end
    end

    // Output registers: buffer read (scandouble) or ce_in-registered bypass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_red_out    <= 2'b00;
            r_green_out  <= 2'b00;
            r_blue_out   <= 2'b00;
            r_hblank_out <= 1'b0;
            r_vblank_out <= 1'b0;
            r_hsync_out  <= 1'b0;
            r_vsync_out  <= 1'b0;
        end else if (!w_mode_sd) begin
            if (ce_in) begin
                r_red_out    <= red_in;
                r_green_out  <= green_in;
                r_blue_out   <= blue_in;
                r_hblank_out <= hblank_in;
                r_vblank_out <= vblank_in;
                r_hsync_out  <= hsync_in;
                r_vsync_out  <= vsync_in;
            end
        end else begin
            r_hsync_out <= ({1'b0, r_rpos} < r_hs_w);
            if (r_rpos == POS_ZERO) begin
                r_vsync_out  <= vsync_in;
                r_vblank_out <= vblank_in;
            end
            if (r_line_len == LEN_ZERO) begin
                r_red_out    <= 2'b00;
                r_green_out  <= 2'b00;
                r_blue_out   <= 2'b00;
                r_hblank_out <= 1'b1;
            end else begin
                {r_hblank_out, r_red_out, r_green_out, r_blue_out} <= r_mem[w_rd_addr];
            end
        end
    end

    assign red_out    = r_red_out;
    assign green_out  = r_green_out;
    assign blue_out   = r_blue_out;
    assign hblank_out = r_hblank_out;
    assign vblank_out = r_vblank_out;
    assign hsync_out  = r_hsync_out;
    assign vsync_out  = r_vsync_out;
    assign line_len   = r_line_len;

endmodule

// File: tb/tb_amstrad_scandoubler.sv
// -----------------------------------------------------------------------------
// Testbench for amstrad_scandoubler: directed lines with hand-computed
// expectations, a bypass vector table, and multi-cycle corner sequences.
// -----------------------------------------------------------------------------
module tb_amstrad_scandoubler;

    localparam int ADDR_W = 10;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sd_en = 1'b1;
    logic            ce_in = 1'b0;
    logic [1:0]      red_in = 2'b00;
    logic [1:0]      green_in = 2'b00;
    logic [1:0]      blue_in = 2'b00;
    logic            hblank_in = 1'b0;
    logic            vblank_in = 1'b0;
    logic            hsync_in = 1'b0;
    logic            vsync_in = 1'b0;
    logic [1:0]      red_out;
    logic [1:0]      green_out;
    logic [1:0]      blue_out;
    logic            hblank_out;
    logic            vblank_out;
    logic            hsync_out;
    logic            vsync_out;
    logic [ADDR_W:0] line_len;

    int checks = 0;
    int errors = 0;

    logic [5:0] cap_pix [0:4095];
    logic       cap_hb  [0:4095];
    logic       cap_hs  [0:4095];
    logic       cap_vs  [0:4095];
    logic       cap_vb  [0:4095];
    int         cidx = 0;

    logic [5:0] le_pix [0:39];
    logic       le_hb  [0:39];

    typedef struct {
        logic [1:0] r, g, b;
        logic       hb, vb, hs, vs;
        logic [1:0] er, eg, eb;
        logic       ehb, evb, ehs, evs;
    } vec_t;

    vec_t vecs [0:7];

    amstrad_scandoubler #(.ADDR_W(ADDR_W), .MIN_LINE(16)) dut (
        .clk(clk), .reset_n(reset_n), .sd_en(sd_en), .ce_in(ce_in),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .hblank_in(hblank_in), .vblank_in(vblank_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
        .hblank_out(hblank_out), .vblank_out(vblank_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .line_len(line_len)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        if (cidx < 4096) begin
            cap_pix[cidx] = {red_out, green_out, blue_out};
            cap_hb[cidx]  = hblank_out;
            cap_hs[cidx]  = hsync_out;
            cap_vs[cidx]  = vsync_out;
            cap_vb[cidx]  = vblank_out;
        end
        cidx++;
    endtask

    // One input pixel: ce_in edge then the idle edge, sampling #1 after each.
    task automatic tick(input logic [5:0] pix, input logic hb, input logic hs,
                        input logic vb, input logic vs);
        {red_in, green_in, blue_in} = pix;
        hblank_in = hb;
        hsync_in  = hs;
        vblank_in = vb;
        vsync_in  = vs;
        ce_in     = 1'b1;
        @(posedge clk); #1; sample();
        ce_in     = 1'b0;
        @(posedge clk); #1; sample();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rgb"},    {26'd0, red_out, green_out, blue_out}, 32'd0);
        chk({tag, "_hblank"}, {31'd0, hblank_out}, 32'd0);
        chk({tag, "_vblank"}, {31'd0, vblank_out}, 32'd0);
        chk({tag, "_hsync"},  {31'd0, hsync_out},  32'd0);
        chk({tag, "_vsync"},  {31'd0, vsync_out},  32'd0);
        chk({tag, "_linelen"}, {21'd0, line_len},  32'd0);
    endtask

    initial begin
        int q;
        // Bypass vectors: output equals the inputs of the same ce_in tick.
        vecs[0] = '{2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{2'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{2'd0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{2'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 2'd2, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1};

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("por");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Preamble (20 ticks, no sync) so the next hsync edge is accepted
        for (int n = 0; n < 20; n++) tick(6'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Line A: 1024 ticks, pixel n = n[5:0], hsync ticks 0..63
        cidx = 0;
        for (int n = 0; n < 1024; n++) tick(n[5:0], (n >= 1000), (n < 64), 1'b0, 1'b0);
        chk("lenA", {21'd0, line_len}, 32'd20);

        // Line B: plays A twice; vsync/vblank rise at tick 300
        cidx = 0;
        for (int n = 0; n < 1024; n++) tick(6'd0, 1'b0, (n < 64), (n >= 300), (n >= 300));
        chk("lenB", {21'd0, line_len}, 32'd1024);
        for (int c = 1; c < 2048; c++) begin
            q = (c - 1) % 1024;
            chk($sformatf("pixB[%0d]", c), {26'd0, cap_pix[c]}, q & 63);
            chk($sformatf("hbB[%0d]", c),  {31'd0, cap_hb[c]}, (q >= 1000) ? 32'd1 : 32'd0);
            chk($sformatf("hsB[%0d]", c),  {31'd0, cap_hs[c]}, (q < 64) ? 32'd1 : 32'd0);
            chk($sformatf("vsB[%0d]", c),  {31'd0, cap_vs[c]}, (c >= 1025) ? 32'd1 : 32'd0);
            chk($sformatf("vbB[%0d]", c),  {31'd0, cap_vb[c]}, (c >= 1025) ? 32'd1 : 32'd0);
        end

        // Line C: 1100 ticks; ticks 1024+ must not reach the buffer
        cidx = 0;
        for (int n = 0; n < 1100; n++)
            tick((n < 1024) ? 6'(n + 7) : 6'h3F, (n >= 1024), (n < 64), 1'b0, 1'b0);
        chk("lenC", {21'd0, line_len}, 32'd1024);

        // Line D: glitch hsync pulse at wpos 8; playback of C must be intact
        cidx = 0;
        for (int n = 0; n < 1024; n++)
            tick(6'd0, 1'b0, (n < 4) || (n == 8) || (n == 9), 1'b0, 1'b0);
        chk("lenD", {21'd0, line_len}, 32'd1024);
        for (int c = 1; c < 2048; c++) begin
            q = (c - 1) % 1024;
            chk($sformatf("pixD[%0d]", c), {26'd0, cap_pix[c]}, (q + 7) & 63);
            chk($sformatf("hbD[%0d]", c),  {31'd0, cap_hb[c]}, 32'd0);
        end

        // Line E: bypass selected at its line start, then the vector table
        sd_en = 1'b0;
        tick(6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        le_pix[0] = 6'd0;
        le_hb[0]  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick({vecs[i].r, vecs[i].g, vecs[i].b}, vecs[i].hb, vecs[i].hs, vecs[i].vb, vecs[i].vs);
            le_pix[i+1] = {vecs[i].r, vecs[i].g, vecs[i].b};
            le_hb[i+1]  = vecs[i].hb;
            chk($sformatf("byp[%0d]_red", i),    {30'd0, red_out},    {30'd0, vecs[i].er});
            chk($sformatf("byp[%0d]_green", i),  {30'd0, green_out},  {30'd0, vecs[i].eg});
            chk($sformatf("byp[%0d]_blue", i),   {30'd0, blue_out},   {30'd0, vecs[i].eb});
            chk($sformatf("byp[%0d]_hblank", i), {31'd0, hblank_out}, {31'd0, vecs[i].ehb});
            chk($sformatf("byp[%0d]_vblank", i), {31'd0, vblank_out}, {31'd0, vecs[i].evb});
            chk($sformatf("byp[%0d]_hsync", i),  {31'd0, hsync_out},  {31'd0, vecs[i].ehs});
            chk($sformatf("byp[%0d]_vsync", i),  {31'd0, vsync_out},  {31'd0, vecs[i].evs});
        end
        for (int n = 9; n < 40; n++) begin
            if (n == 20) sd_en = 1'b1;   // mid-line: must not take effect yet
            tick(6'(n * 5), 1'b0, 1'b0, 1'b0, 1'b0);
            le_pix[n] = 6'(n * 5);
            le_hb[n]  = 1'b0;
            if (n == 25) chk("bypass_after_sd_en", {26'd0, red_out, green_out, blue_out}, 32'd61);
        end

        // Line F: doubling resumes, playing the 40-tick line E
        cidx = 0;
        for (int n = 0; n < 40; n++) tick(6'h2A, 1'b1, (n < 3), 1'b0, 1'b0);
        chk("lenF", {21'd0, line_len}, 32'd40);
        for (int c = 1; c < 80; c++) begin
            q = (c - 1) % 40;
            chk($sformatf("pixF[%0d]", c), {26'd0, cap_pix[c]}, {26'd0, le_pix[q]});
            chk($sformatf("hbF[%0d]", c),  {31'd0, cap_hb[c]}, {31'd0, le_hb[q]});
            chk($sformatf("hsF[%0d]", c),  {31'd0, cap_hs[c]}, (q < 3) ? 32'd1 : 32'd0);
        end

        // Line G: asynchronous reset in the middle of the line
        for (int n = 0; n < 10; n++) tick(6'h2A, 1'b1, (n < 3), 1'b0, 1'b0);
        chk("preG_rgb", {26'd0, red_out, green_out, blue_out}, 32'h2A);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("postreset_len", {21'd0, line_len}, 32'd0);

        // First line after reset: nothing accepted yet, output blanked
        cidx = 0;
        for (int n = 0; n < 30; n++) tick(6'h3F, 1'b0, (n < 3), 1'b0, 1'b0);
        for (int c = 0; c < 60; c++) begin
            chk($sformatf("blank_rgb[%0d]", c), {26'd0, cap_pix[c]}, 32'd0);
            chk($sformatf("blank_hb[%0d]", c),  {31'd0, cap_hb[c]}, 32'd1);
        end
        chk("blank_len", {21'd0, line_len}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
